// File: rtl/sdram_arbit_if.sv
// ---------------------------------------------------------------------------
// sdram_arbit_if
// Bundles the signals between the SDRAM arbiter and the command engines and
// SDRAM pins.
//   slave  modport : the arbiter. It takes the requests, commands and write
//                    data, and drives the grants and the SDRAM pins.
//   master modport : the engines and the pin consumer. They drive requests,
//                    commands, end pulses and write data, and see the grants
//                    and pins.
// sdram_dq is a bidirectional bus, so it is kept as a separate inout port on
// the arbiter and is not part of this interface.
// ---------------------------------------------------------------------------
interface sdram_arbit_if #(
    parameter int DQ_W = 16
);
    logic            init_end;
    logic [3:0]      init_cmd;
    logic [1:0]      init_ba;
    logic [12:0]     init_addr;

    logic            aref_req;
    logic [3:0]      aref_cmd;
    logic [1:0]      aref_ba;
    logic [12:0]     aref_addr;
    logic            aref_end;

    logic            wr_req;
    logic [3:0]      wr_cmd;
    logic [1:0]      wr_ba;
    logic [12:0]     wr_addr;
    logic            wr_end;
    logic            wr_sdram_en;
    logic [DQ_W-1:0] wr_sdram_data;

    logic            rd_req;
    logic [3:0]      rd_cmd;
    logic [1:0]      rd_ba;
    logic [12:0]     rd_addr;
    logic            rd_end;

    logic            aref_en;
    logic            wr_en;
    logic            rd_en;

    logic            sdram_cke;
    logic            sdram_cs_n;
    logic            sdram_ras_n;
    logic            sdram_cas_n;
    logic            sdram_we_n;
    logic [1:0]      sdram_ba;
    logic [12:0]     sdram_addr;

    modport slave (
        input  init_end, init_cmd, init_ba, init_addr,
        input  aref_req, aref_cmd, aref_ba, aref_addr, aref_end,
        input  wr_req, wr_cmd, wr_ba, wr_addr, wr_end, wr_sdram_en, wr_sdram_data,
        input  rd_req, rd_cmd, rd_ba, rd_addr, rd_end,
        output aref_en, wr_en, rd_en,
        output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        output sdram_ba, sdram_addr
    );

    modport master (
        output init_end, init_cmd, init_ba, init_addr,
        output aref_req, aref_cmd, aref_ba, aref_addr, aref_end,
        output wr_req, wr_cmd, wr_ba, wr_addr, wr_end, wr_sdram_en, wr_sdram_data,
        output rd_req, rd_cmd, rd_ba, rd_addr, rd_end,
        input  aref_en, wr_en, rd_en,
        input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        input  sdram_ba, sdram_addr
    );
endinterface

// File: rtl/sdram_arbit.sv
// ---------------------------------------------------------------------------
// sdram_arbit
// Arbitrates the SDRAM command bus between the init, auto-refresh, write and
// read engines.
//
// Ports
//   sys_clk   : system clock (100 MHz)
//   sys_rst   : asynchronous active-high reset
//   bus       : sdram_arbit_if.slave. It carries the engine requests,
//               commands and end pulses, the write data, the grants
//               (aref_en / wr_en / rd_en) and the SDRAM command pins.
//   sdram_dq  : SDRAM data bus. It is driven only during a write.
//
// Behaviour
// After init_end, the arbiter sits in ARBIT. Each cycle it grants by fixed
// priority: refresh first, then write, then read. A grant is held until the
// matching end pulse. There is no preemption. Every grant passes through one
// ARBIT cycle, and during that cycle a NOP is driven on the pins.
// ---------------------------------------------------------------------------
module sdram_arbit #(
    parameter int DQ_W = 16
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    sdram_arbit_if.slave    bus,
    inout  wire [DQ_W-1:0]  sdram_dq
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    localparam logic [3:0]  NOP_CMD  = 4'b0111;
    localparam logic [1:0]  NOP_BA   = 2'b11;
    localparam logic [12:0] NOP_ADDR = 13'h1fff;

    state_t      state_r;
    logic        cke_r;
    logic [3:0]  cmd_s;
    logic [1:0]  ba_s;
    logic [12:0] addr_s;
    logic        dq_oe_s;

    // State transitions and clock-enable register. Any state outside the
    // legal set falls back to INIT.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r <= ST_INIT;
            cke_r   <= 1'b0;
        end else begin
            cke_r <= 1'b1;
            case (state_r)
                ST_INIT: begin
                    if (bus.init_end) state_r <= ST_ARBIT;
                end
                ST_ARBIT: begin
                    if (bus.aref_req)    state_r <= ST_AREF;
                    else if (bus.wr_req) state_r <= ST_WRITE;
                    else if (bus.rd_req) state_r <= ST_READ;
                end
                // End pulses that do not belong to the current owner are ignored.
                ST_AREF: begin
                    if (bus.aref_end) state_r <= ST_ARBIT;
                end
                ST_WRITE: begin
                    if (bus.wr_end) state_r <= ST_ARBIT;
                end
                ST_READ: begin
                    if (bus.rd_end) state_r <= ST_ARBIT;
                end
                default: state_r <= ST_INIT;
            endcase
        end
    end

    // Grant decode. The grants are one-hot by construction, because each
    // grant maps to its own state.
    always_comb begin
        bus.aref_en = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        case (state_r)
            ST_AREF:  bus.aref_en = 1'b1;
            ST_WRITE: bus.wr_en   = 1'b1;
            ST_READ:  bus.rd_en   = 1'b1;
            default: begin
                bus.aref_en = 1'b0;
                bus.wr_en   = 1'b0;
                bus.rd_en   = 1'b0;
            end
        endcase
    end

    // Command/bank/address mux. ARBIT and any unknown state drive a NOP.
    always_comb begin
        cmd_s  = NOP_CMD;
        ba_s   = NOP_BA;
        addr_s = NOP_ADDR;
        case (state_r)
            ST_INIT: begin
                cmd_s  = bus.init_cmd;
                ba_s   = bus.init_ba;
                addr_s = bus.init_addr;
            end
            ST_AREF: begin
                cmd_s  = bus.aref_cmd;
                ba_s   = bus.aref_ba;
                addr_s = bus.aref_addr;
            end
            ST_WRITE: begin
                cmd_s  = bus.wr_cmd;
                ba_s   = bus.wr_ba;
                addr_s = bus.wr_addr;
            end
            ST_READ: begin
                cmd_s  = bus.rd_cmd;
                ba_s   = bus.rd_ba;
                addr_s = bus.rd_addr;
            end
            default: begin
                cmd_s  = NOP_CMD;
                ba_s   = NOP_BA;
                addr_s = NOP_ADDR;
            end
        endcase
    end

    // Data bus enable. The write engine owns the bus only while it is granted.
    always_comb begin
        if (bus.wr_sdram_en && (state_r == ST_WRITE)) dq_oe_s = 1'b1;
        else                                          dq_oe_s = 1'b0;
    end

    assign {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} = cmd_s;
    assign bus.sdram_ba   = ba_s;
    assign bus.sdram_addr = addr_s;
    assign bus.sdram_cke  = cke_r;
    assign sdram_dq       = dq_oe_s ? bus.wr_sdram_data : {DQ_W{1'bz}};

endmodule
